// File: rtl/mem_pkg.sv
// Shared types and the address-derived fill pattern for the memory fill/check sequencer.
// MEM_FILL_CHECK_INV_PASS_EN adds the inverted-pattern states to fc_state_t.
package mem_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_BITS  = 5;

`ifdef MEM_FILL_CHECK_INV_PASS_EN
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_CMP,
        DONE,
        WRITE_INV,
        RD_ADDR_INV,
        RD_CMP_INV
    } fc_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_CMP,
        DONE
    } fc_state_t;
`endif

    // Computed at 32 bits so callers of any word width just truncate; the
    // low bits of ~(a+b) equal the inverse of the truncated sum.
    function automatic logic [31:0] exp_pattern(input logic [31:0] base,
                                                input logic [31:0] idx,
                                                input logic        inv);
        logic [31:0] sum;
        sum = base + idx;
        return inv ? ~sum : sum;
    endfunction

endpackage

// File: rtl/mem_fill_check_cmp.sv
// Registered comparator: counts readback mismatches and remembers the first failing address.
module mem_fill_check_cmp
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int ADDR_BITS  = mem_pkg::ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  cmp_en,
    input  logic [ADDR_BITS-1:0]  idx,
    input  logic [DATA_WIDTH-1:0] expected,
    input  logic [DATA_WIDTH-1:0] actual,
    output logic [ADDR_BITS+1:0]  err_count,
    output logic [ADDR_BITS-1:0]  first_err_addr
);

    localparam int ERR_W = ADDR_BITS + 2;

    logic [ERR_W-1:0]     err_count_q, err_count_d;
    logic [ADDR_BITS-1:0] first_err_addr_q, first_err_addr_d;
    logic                 mismatch;

    always_comb begin
        mismatch         = cmp_en && (expected != actual);
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        if (clear) begin
            err_count_d      = '0;
            first_err_addr_d = '0;
        end else if (mismatch) begin
            if (err_count_q == '0) begin
                first_err_addr_d = idx;
            end
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: rtl/mem_fill_check.sv
// Fill-then-verify sequencer driving reg_mem; reports pass, error count and first failing address.
// Define MEM_FILL_CHECK_INV_PASS_EN to add a second pass with the inverted pattern.
module mem_fill_check
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int ADDR_BITS  = mem_pkg::ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS+1:0]  err_count,
    output logic [ADDR_BITS-1:0]  first_err_addr,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;

    fc_state_t             state_q, state_d;
    logic [ADDR_BITS-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic                  pass_q, pass_d;

    logic                  clear;
    logic                  cmp_en;
    logic                  inv_pass;
    logic [DATA_WIDTH-1:0] exp_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        pass_d  = pass_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base;
                    idx_d   = '0;
                    pass_d  = 1'b0;
                    clear   = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = RD_ADDR;
                end else begin
                    idx_d = idx_q + ADDR_BITS'(1);
                end
            end
            RD_ADDR: state_d = RD_CMP;
            RD_CMP: begin
                if (idx_q == LAST_IDX) begin
`ifdef MEM_FILL_CHECK_INV_PASS_EN
                    idx_d   = '0;
                    state_d = WRITE_INV;
`else
                    state_d = DONE;
`endif
                end else begin
                    idx_d   = idx_q + ADDR_BITS'(1);
                    state_d = RD_ADDR;
                end
            end
`ifdef MEM_FILL_CHECK_INV_PASS_EN
            WRITE_INV: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = RD_ADDR_INV;
                end else begin
                    idx_d = idx_q + ADDR_BITS'(1);
                end
            end
            RD_ADDR_INV: state_d = RD_CMP_INV;
            RD_CMP_INV: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_BITS'(1);
                    state_d = RD_ADDR_INV;
                end
            end
`endif
            DONE: begin
                pass_d  = (err_count == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The pattern is a pure function of base and index, so the readback
    // expectation is recomputed rather than stored.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        pass        = (state_q == DONE) ? (err_count == '0) : pass_q;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        cmp_en      = 1'b0;
        inv_pass    = 1'b0;
        unique case (state_q)
            WRITE: begin
                mem_wen  = 1'b1;
                mem_addr = idx_q;
            end
            RD_ADDR: mem_addr = idx_q;
            RD_CMP: begin
                mem_addr = idx_q;
                cmp_en   = 1'b1;
            end
`ifdef MEM_FILL_CHECK_INV_PASS_EN
            WRITE_INV: begin
                mem_wen  = 1'b1;
                mem_addr = idx_q;
                inv_pass = 1'b1;
            end
            RD_ADDR_INV: begin
                mem_addr = idx_q;
                inv_pass = 1'b1;
            end
            RD_CMP_INV: begin
                mem_addr = idx_q;
                cmp_en   = 1'b1;
                inv_pass = 1'b1;
            end
`endif
            default: ;
        endcase
        exp_val     = DATA_WIDTH'(exp_pattern(32'(base_q), 32'(idx_q), inv_pass));
        mem_data_in = mem_wen ? exp_val : '0;
    end

    mem_fill_check_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_cmp (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .cmp_en         (cmp_en),
        .idx            (idx_q),
        .expected       (exp_val),
        .actual         (mem_data_out),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_mem_fill_check.sv
// Directed bench for mem_fill_check with a registered-read memory model and stuck-at fault injection.
// Build with MEM_FILL_CHECK_INV_PASS_EN defined to exercise the inverted second pass.
module tb_mem_fill_check;

    localparam int DEPTH = 32;
`ifdef MEM_FILL_CHECK_INV_PASS_EN
    localparam int RUN_LEN = 193;
`else
    localparam int RUN_LEN = 97;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_count;
    logic [4:0] first_err_addr;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_wen;
    logic [7:0] mem_data_out;

    int tests;
    int fails;

    logic [7:0] mem_arr [DEPTH];
    logic [7:0] rd_q;
    logic       fault_a_en;
    logic       fault_b_en;

    int         done_cnt;
    int         done_at;
    int         busy_cnt;
    int         wr_bad;
    int         err_at_1;
    int         pass_at_1;
    logic       pass_at_done;
    logic [7:0] wr_log [2*DEPTH];

    mem_fill_check dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base           (base),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_wen        (mem_wen),
        .mem_data_out   (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with a one-cycle registered read; faults force bit 2 low on readback.
    function automatic logic [7:0] faulty(input logic [4:0] a, input logic [7:0] d);
        if ((fault_a_en && a == 5'd5) || (fault_b_en && a == 5'd20)) return d & 8'hFB;
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_wen) mem_arr[mem_addr] <= mem_data_in;
        rd_q <= faulty(mem_addr, mem_arr[mem_addr]);
    end
    assign mem_data_out = rd_q;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        base  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts a run and watches it for a bounded number of cycles; k counts
    // cycles after the start-accepting edge.
    task automatic runOne(input logic [7:0] b, input int mid_start_k, input int reset_k);
        logic [7:0] e;
        done_cnt     = 0;
        done_at      = 0;
        busy_cnt     = 0;
        wr_bad       = 0;
        err_at_1     = -1;
        pass_at_1    = -1;
        pass_at_done = 1'bx;
        applyStimulus(b);
        for (int k = 1; k <= RUN_LEN + 4; k++) begin
            if (k == 1) begin
                err_at_1  = 32'(err_count);
                pass_at_1 = 32'(pass);
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
                pass_at_done = pass;
            end
            if (k <= DEPTH) begin
                e = b + 8'(k - 1);
                wr_log[k-1] = mem_data_in;
                if (!(mem_wen === 1'b1 && mem_addr === 5'(k - 1) && mem_data_in === e)) wr_bad++;
            end
`ifdef MEM_FILL_CHECK_INV_PASS_EN
            if (k > 3*DEPTH && k <= 4*DEPTH) begin
                e = ~(b + 8'(k - 3*DEPTH - 1));
                wr_log[k-2*DEPTH-1] = mem_data_in;
                if (!(mem_wen === 1'b1 && mem_addr === 5'(k - 3*DEPTH - 1) && mem_data_in === e)) wr_bad++;
            end
`endif
            start = (k == mid_start_k);
            if (k == reset_k) begin
                rst_n = 1'b0;
                #1;
                checkOutput("wen_drop_on_reset", 32'(mem_wen), 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_pass"}, 32'(pass), 0);
        checkOutput({tag, "_err_count"}, 32'(err_count), 0);
        checkOutput({tag, "_first_err"}, 32'(first_err_addr), 0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 0);
        checkOutput({tag, "_mem_data_in"}, 32'(mem_data_in), 0);
        checkOutput({tag, "_mem_wen"}, 32'(mem_wen), 0);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base       = 8'h00;
        fault_a_en = 1'b0;
        fault_b_en = 1'b0;
        repeat (2) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] clean run, base=10");
        runOne(8'd10, -1, -1);
        checkOutput("pass_done_cycle", 32'(done_at), 32'(RUN_LEN));
        checkOutput("pass_done_count", 32'(done_cnt), 1);
        checkOutput("pass_busy_cycles", 32'(busy_cnt), 32'(RUN_LEN));
        checkOutput("pass_write_seq_bad", 32'(wr_bad), 0);
        checkOutput("pass_wr_addr0", 32'(wr_log[0]), 32'd10);
        checkOutput("pass_wr_addr31", 32'(wr_log[31]), 32'd41);
        checkOutput("pass_at_done", 32'(pass_at_done), 1);
        checkOutput("pass_held", 32'(pass), 1);
        checkOutput("pass_err_count", 32'(err_count), 0);
        checkOutput("pass_first_err", 32'(first_err_addr), 0);
        checkOutput("pass_busy_idle", 32'(busy), 0);

        $display("[TB] wrap-around run, base=F0");
        runOne(8'hF0, -1, -1);
        checkOutput("wrap_write_seq_bad", 32'(wr_bad), 0);
        checkOutput("wrap_wr_addr15", 32'(wr_log[15]), 32'hFF);
        checkOutput("wrap_wr_addr16", 32'(wr_log[16]), 32'h00);
        checkOutput("wrap_wr_addr31", 32'(wr_log[31]), 32'h0F);
        checkOutput("wrap_pass", 32'(pass), 1);

        $display("[TB] faults at 5 and 20, base=0, extra start at cycle 40");
        fault_a_en = 1'b1;
        fault_b_en = 1'b1;
        runOne(8'h00, 40, -1);
        checkOutput("fault_done_count", 32'(done_cnt), 1);
        checkOutput("fault_done_cycle", 32'(done_at), 32'(RUN_LEN));
        checkOutput("fault_err_count", 32'(err_count), 2);
        checkOutput("fault_first_err", 32'(first_err_addr), 5);
        checkOutput("fault_pass_at_done", 32'(pass_at_done), 0);
        checkOutput("fault_pass", 32'(pass), 0);
        checkOutput("fault_busy_idle", 32'(busy), 0);

        $display("[TB] restart after failing run, base=55");
        fault_a_en = 1'b0;
        fault_b_en = 1'b0;
        runOne(8'h55, -1, -1);
        checkOutput("restart_err_cleared", 32'(err_at_1), 0);
        checkOutput("restart_pass_cleared", 32'(pass_at_1), 0);
        checkOutput("restart_err_count", 32'(err_count), 0);
        checkOutput("restart_first_err", 32'(first_err_addr), 0);
        checkOutput("restart_pass", 32'(pass), 1);

        $display("[TB] reset at cycle 10 of WRITE");
        runOne(8'h77, -1, 10);
        checkOutput("abort_done_count", 32'(done_cnt), 0);
        checkReset("abort");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] run after abort, base=3");
        runOne(8'h03, -1, -1);
        checkOutput("after_done_cycle", 32'(done_at), 32'(RUN_LEN));
        checkOutput("after_write_seq_bad", 32'(wr_bad), 0);
        checkOutput("after_wr_addr31", 32'(wr_log[31]), 32'd34);
        checkOutput("after_pass", 32'(pass), 1);

`ifdef MEM_FILL_CHECK_INV_PASS_EN
        $display("[TB] inverted pass, fault at 5 only, base=0");
        fault_a_en = 1'b1;
        runOne(8'h00, -1, -1);
        checkOutput("inv_done_cycle", 32'(done_at), 193);
        checkOutput("inv_write_seq_bad", 32'(wr_bad), 0);
        checkOutput("inv_wr_addr0", 32'(wr_log[32]), 32'hFF);
        checkOutput("inv_wr_addr31", 32'(wr_log[63]), 32'hE0);
        checkOutput("inv_err_count", 32'(err_count), 1);
        checkOutput("inv_first_err", 32'(first_err_addr), 5);
        checkOutput("inv_pass", 32'(pass), 0);
        fault_a_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
